// File: rtl/mac_share_arbiter_if.sv
// Handshake bundle between the requesters/consumer and mac_share_arbiter:
// req/gnt with packed operands on the request side, valid/ready on the result side.
interface mac_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ*W-1:0] i_a;
  logic [N_REQ*W-1:0] i_b;
  logic [N_REQ*W-1:0] i_c;
  logic [N_REQ-1:0]   i_mode;
  logic               i_ready;
  logic [N_REQ-1:0]   o_gnt;
  logic               o_valid;
  logic [2*W-1:0]     o_answer;
  logic [ID_W-1:0]    o_id;

  modport slave (
    input  i_req, i_a, i_b, i_c, i_mode, i_ready,
    output o_gnt, o_valid, o_answer, o_id
  );

  modport master (
    output i_req, i_a, i_b, i_c, i_mode, i_ready,
    input  o_gnt, o_valid, o_answer, o_id
  );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter feeding one shared a*b+c datapath through a two-stage
// pipeline (operand register S1, output register S2) with valid/ready output.
module mac_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mac_share_arbiter_if.slave bus
);
  localparam int            RW     = 2 * W;
  localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(N_REQ);

  // Operands are widened to 2W (sign- or zero-extended); the low 2W bits of
  // the product are identical for both interpretations once extended.
  function automatic logic [RW-1:0] mac_fn(input logic [W-1:0] a, b, c,
                                            input logic sgn);
    logic signed [RW-1:0] a_x, b_x, c_x;
    if (sgn) begin
      a_x = RW'($signed(a));
      b_x = RW'($signed(b));
      c_x = RW'($signed(c));
    end else begin
      a_x = $signed({{W{1'b0}}, a});
      b_x = $signed({{W{1'b0}}, b});
      c_x = $signed({{W{1'b0}}, c});
    end
    return $unsigned(a_x * b_x + c_x);
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      s1_a_q, s1_b_q, s1_c_q;
  logic              s1_mode_q;
  logic [ID_W-1:0]   s1_id_q;
  logic              o_valid_q, o_valid_d;
  logic [RW-1:0]     o_answer_q, o_answer_d;
  logic [ID_W-1:0]   o_id_q, o_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              adv2, acc1;
  logic [N_REQ-1:0]  gnt;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     scan_idx;
  logic [W-1:0]      sel_a, sel_b, sel_c;
  logic              sel_mode;

  assign adv2 = s1_valid_q & (~o_valid_q | bus.i_ready);
  assign acc1 = ~s1_valid_q | adv2;

  // Search from ptr upward with wrap; the first requesting index wins.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (i_rst_n && acc1) begin
      for (int off = 0; off < N_REQ; off++) begin
        scan_idx = {1'b0, ptr_q} + (ID_W + 1)'(off);
        if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
        if (!gnt_any && bus.i_req[scan_idx[ID_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx[ID_W-1:0];
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_c    = '0;
    sel_mode = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_a    = bus.i_a[k*W +: W];
        sel_b    = bus.i_b[k*W +: W];
        sel_c    = bus.i_c[k*W +: W];
        sel_mode = bus.i_mode[k];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    ptr_d      = ptr_q;
    o_valid_d  = o_valid_q;
    o_answer_d = o_answer_q;
    o_id_d     = o_id_q;
    if (acc1) s1_valid_d = gnt_any;
    if (gnt_any) ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    if (adv2) begin
      o_valid_d  = 1'b1;
      o_answer_d = mac_fn(s1_a_q, s1_b_q, s1_c_q, s1_mode_q);
      o_id_d     = s1_id_q;
    end else if (bus.i_ready) begin
      o_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      ptr_q      <= '0;
      o_valid_q  <= 1'b0;
      o_answer_q <= '0;
      o_id_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ptr_q      <= ptr_d;
      o_valid_q  <= o_valid_d;
      o_answer_q <= o_answer_d;
      o_id_q     <= o_id_d;
    end
  end

  // S1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (gnt_any) begin
      s1_a_q    <= sel_a;
      s1_b_q    <= sel_b;
      s1_c_q    <= sel_c;
      s1_mode_q <= sel_mode;
      s1_id_q   <= gnt_idx;
    end
  end

  assign bus.o_gnt    = gnt;
  assign bus.o_valid  = o_valid_q;
  assign bus.o_answer = o_answer_q;
  assign bus.o_id     = o_id_q;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Bench for mac_share_arbiter: directed plan items plus random traffic, all
// checked against a queue-based reference of the shared multiply-add pipeline.
module tb_mac_share_arbiter;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  typedef struct { int ans; int id; } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_share_arbiter_if #(.N_REQ(N), .W(W), .ID_W(ID_W)) bus ();
  mac_share_arbiter #(.N_REQ(N), .W(W), .ID_W(ID_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference: results in grant order; head is on the output when mvld=1,
  // any remaining entry sits in the operand stage.
  res_t         q[$];
  bit           mvld;
  int           mptr;
  int           n_vec, n_err;
  logic [N-1:0] g_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_mac(int a, int b, int c, bit sgn);
    int r;
    if (sgn) begin
      if (a >= 2**(W-1)) a -= 2**W;
      if (b >= 2**(W-1)) b -= 2**W;
      if (c >= 2**(W-1)) c -= 2**W;
    end
    r = a * b + c;
    return r & (2**(2*W) - 1);
  endfunction

  task automatic set_ops(input int k, input logic [W-1:0] a, b, c, input logic m);
    bus.i_a[k*W +: W] = a;
    bus.i_b[k*W +: W] = b;
    bus.i_c[k*W +: W] = c;
    bus.i_mode[k]     = m;
  endtask

  task automatic rand_ops(input int k);
    set_ops(k, W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    bit           s1full, adv, acc;
    int           gidx, kk;
    logic [N-1:0] eg;
    res_t         r;
    #1;
    s1full = (q.size() > (mvld ? 1 : 0));
    adv    = s1full && (!mvld || bus.i_ready);
    acc    = !s1full || adv;
    gidx   = -1;
    if (acc) begin
      for (int off = 0; off < N; off++) begin
        kk = (mptr + off) % N;
        if (gidx < 0 && bus.i_req[kk]) gidx = kk;
      end
    end
    eg = '0;
    if (gidx >= 0) eg[gidx] = 1'b1;
    g_obs = bus.o_gnt;
    chk("gnt", 32'(g_obs), 32'(eg));
    @(posedge clk);
    if (mvld && bus.i_ready) begin
      r    = q.pop_front();
      mvld = 1'b0;
    end
    if (adv) mvld = 1'b1;
    if (gidx >= 0) begin
      r.ans = model_mac(int'(bus.i_a[gidx*W +: W]), int'(bus.i_b[gidx*W +: W]),
                        int'(bus.i_c[gidx*W +: W]), bus.i_mode[gidx]);
      r.id  = gidx;
      q.push_back(r);
      mptr = (gidx + 1) % N;
    end
    #1;
    chk("o_valid", 32'(bus.o_valid), 32'(mvld));
    if (mvld) begin
      chk("o_answer", 32'(bus.o_answer), 32'(q[0].ans));
      chk("o_id", 32'(bus.o_id), 32'(q[0].id));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bus.i_req   = '0;
    bus.i_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic single(input int k, input logic [W-1:0] a, b, c, input logic m,
                        input logic [2*W-1:0] exp, input string tag);
    bus.i_req   = '0;
    bus.i_ready = 1'b1;
    set_ops(k, a, b, c, m);
    bus.i_req[k] = 1'b1;
    step();
    chk({tag, "_gnt"}, 32'(g_obs), 32'(1 << k));
    bus.i_req = '0;
    step();
    chk({tag, "_vld"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_ans"}, 32'(bus.o_answer), 32'(exp));
    chk({tag, "_id"}, 32'(bus.o_id), 32'(k));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_vec = 0;
    n_err = 0;
    mvld  = 1'b0;
    mptr  = 0;
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_req   = '1;
    for (int k = 0; k < N; k++) set_ops(k, W'(k + 1), W'(k + 2), W'(k), 1'(k));

    // Reset values, with every requester asserting.
    #2;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_answer", 32'(bus.o_answer), 32'd0);
    chk("rst_o_id", 32'(bus.o_id), 32'd0);
    chk("rst_o_gnt", 32'(bus.o_gnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness from reset, no gap cycles on the output.
    for (int n = 1; n <= 6; n++) begin
      step();
      chk("rr_gnt", 32'(g_obs), 32'(1 << ((n - 1) % 4)));
      if (n >= 2) begin
        chk("rr_vld", 32'(bus.o_valid), 32'd1);
        chk("rr_id", 32'(bus.o_id), 32'((n - 2) % 4));
      end
    end
    drain();

    // Arithmetic: basic unsigned, signed vs unsigned, corners.
    single(2, 4'h3, 4'h5, 4'h2, 1'b0, 8'h11, "basic");
    single(0, 4'hE, 4'h3, 4'hF, 1'b1, 8'hF9, "smode");
    single(0, 4'hE, 4'h3, 4'hF, 1'b0, 8'h39, "umode");
    single(0, 4'h8, 4'h8, 4'h7, 1'b1, 8'h47, "scorner");
    single(1, 4'hF, 4'hF, 4'hF, 1'b0, 8'hF0, "ucorner");

    // Backpressure: two grants fill the pipeline, then grants stop.
    rand_ops(1);
    bus.i_req   = 4'b0010;
    bus.i_ready = 1'b0;
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (g_obs[1]) begin
        cnt++;
        rand_ops(1);
      end
    end
    chk("bp_grants", 32'(cnt), 32'd2);
    chk("bp_gnt_off", 32'(g_obs), 32'd0);
    bus.i_ready = 1'b1;
    step();
    chk("bp_resume", 32'(g_obs), 32'b0010);
    rand_ops(1);
    step();
    step();
    drain();

    // Pointer skip over idle requesters, starting from ptr=2.
    rand_ops(1);
    bus.i_req = 4'b0010;
    step();
    rand_ops(1);
    rand_ops(3);
    bus.i_req = 4'b1010;
    step();
    chk("skip_g0", 32'(g_obs), 32'b1000);
    rand_ops(3);
    step();
    chk("skip_g1", 32'(g_obs), 32'b0010);
    rand_ops(1);
    step();
    chk("skip_g2", 32'(g_obs), 32'b1000);
    drain();

    // Asynchronous reset with both stages full.
    bus.i_ready = 1'b0;
    bus.i_req   = '1;
    step();
    step();
    chk("rst_pre_vld", 32'(bus.o_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(bus.o_valid), 32'd0);
    chk("rst_mid_gnt", 32'(bus.o_gnt), 32'd0);
    q.delete();
    mvld = 1'b0;
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    step();
    chk("rst_first_gnt", 32'(g_obs), 32'b0001);
    drain();

    // Random traffic: requests come and go, ready toggles.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        if (bus.i_req[k]) begin
          if ($urandom_range(7) == 0) bus.i_req[k] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          rand_ops(k);
          bus.i_req[k] = 1'b1;
        end
      end
      bus.i_ready = ($urandom_range(9) < 7);
      step();
      for (int k = 0; k < N; k++) if (g_obs[k]) bus.i_req[k] = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
